fft_btf_sched: RTL and testbench

- Sequencer for the radix-2 decimation-in-frequency FFT butterfly datapath.
- Walks stage / group / step counters and issues one butterfly per accepted cycle, with data indices a and b and twiddle index wn.
- Tracks butterflies in flight through the fixed-latency butterfly unit and emits matching writeback indices.
- Drains between stages so stage s+1 never reads data that stage s has not yet written. Sits between the FFT top, the data/twiddle RAM ports and the butterfly unit.

---
 rtl/fft_pkg.sv | 25 ++
 rtl/fft_wb_pipe.sv | 59 +++++
 rtl/fft_btf_sched.sv | 184 ++++++++++++++++++
 tb/tb_fft_btf_sched.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types and helpers for the FFT butterfly scheduler
package fft_pkg;

    localparam int MAX_LOG2N = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_REORDER,
        ST_DONE
    } fft_state_t;

    // Reverses the low nbits of val; higher bits of the result are zero.
    function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] val,
                                                    input int nbits);
        logic [MAX_LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_LOG2N; i++) begin
            if (i < nbits) r[i] = val[nbits-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_wb_pipe.sv
// rtl/fft_wb_pipe.sv - fixed-latency writeback delay line with in-flight counter
// Mirrors the butterfly unit latency; never stalls once an issue is accepted.
module fft_wb_pipe #(
    parameter int BTF_LAT = 3,
    parameter int AW      = 16,
    parameter int CW      = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [AW-1:0] a_i,
    input  logic [AW-1:0] b_i,
    output logic          wb_vld_o,
    output logic [AW-1:0] wb_a_o,
    output logic [AW-1:0] wb_b_o,
    output logic [CW-1:0] inflight_o
);

    logic [BTF_LAT-1:0]         vld_q;
    logic [BTF_LAT-1:0][AW-1:0] a_q;
    logic [BTF_LAT-1:0][AW-1:0] b_q;
    logic [CW-1:0]              cnt_q;
    logic [CW-1:0]              cnt_d;

    assign wb_vld_o   = vld_q[BTF_LAT-1];
    assign wb_a_o     = a_q[BTF_LAT-1];
    assign wb_b_o     = b_q[BTF_LAT-1];
    assign inflight_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (push_i && !wb_vld_o) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push_i && wb_vld_o) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Indices are zeroed on empty slots so wb_a/wb_b read 0 when not valid.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
        end else begin
            vld_q[0] <= push_i;
            a_q[0]   <= push_i ? a_i : '0;
            b_q[0]   <= push_i ? b_i : '0;
            for (int i = 1; i < BTF_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                a_q[i]   <= a_q[i-1];
                b_q[i]   <= b_q[i-1];
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fft_btf_sched.sv
// rtl/fft_btf_sched.sv - radix-2 DIF FFT butterfly issue/writeback sequencer
// Optional bit-reversed output reorder phase: FFT_SCHED_BITREV_EN.
module fft_btf_sched
    import fft_pkg::*;
#(
    parameter int LOG2N   = 3,
    parameter int BTF_LAT = 3,
    parameter int AW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          iss_vld,
    input  logic          iss_rdy,
    output logic [AW-1:0] iss_a,
    output logic [AW-1:0] iss_b,
    output logic [AW-1:0] iss_wn,
    output logic [7:0]    stage,
    output logic          wb_vld,
    output logic [AW-1:0] wb_a,
    output logic [AW-1:0] wb_b
`ifdef FFT_SCHED_BITREV_EN
    ,
    output logic          out_vld,
    output logic [AW-1:0] out_idx
`endif
);

    localparam int N  = 1 << LOG2N;
    localparam int CW = $clog2(BTF_LAT + 2);

    fft_state_t    state_q, state_d;
    logic [7:0]    stage_q, stage_d;
    logic [AW-1:0] a_q, a_d;
    logic [AW-1:0] wn_q, wn_d;
    logic [AW-1:0] k_q, k_d;
    logic [AW-1:0] g_q, g_d;
    logic [AW-1:0] half;
    logic [AW-1:0] groups;
    logic [AW-1:0] b_idx;
    logic [CW-1:0] inflight;
    logic          hs;
    logic          last_k;
    logic          last_g;
    logic          final_stage;
`ifdef FFT_SCHED_BITREV_EN
    logic [LOG2N-1:0] ro_q, ro_d;
`endif

    assign half        = AW'(N) >> (stage_q + 8'd1);
    assign groups      = AW'(1) << stage_q;
    assign b_idx       = a_q + half;
    assign hs          = iss_vld && iss_rdy;
    assign last_k      = (k_q == half - AW'(1));
    assign last_g      = (g_q == groups - AW'(1));
    assign final_stage = (stage_q == 8'(LOG2N - 1));

    assign iss_vld = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign busy    = (state_q == ST_RUN) || (state_q == ST_DRAIN) || (state_q == ST_REORDER);
    assign iss_a   = iss_vld ? a_q   : '0;
    assign iss_b   = iss_vld ? b_idx : '0;
    assign iss_wn  = iss_vld ? wn_q  : '0;
    assign stage   = stage_q;

`ifdef FFT_SCHED_BITREV_EN
    assign out_vld = (state_q == ST_REORDER);
    assign out_idx = out_vld ? AW'(bitrev(MAX_LOG2N'(ro_q), LOG2N)) : '0;
`endif

    fft_wb_pipe #(
        .BTF_LAT (BTF_LAT),
        .AW      (AW),
        .CW      (CW)
    ) u_wb_pipe (
        .clk_i      (clk),
        .rst_i      (rst),
        .push_i     (hs),
        .a_i        (a_q),
        .b_i        (b_idx),
        .wb_vld_o   (wb_vld),
        .wb_a_o     (wb_a),
        .wb_b_o     (wb_b),
        .inflight_o (inflight)
    );

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        a_d     = a_q;
        wn_d    = wn_q;
        k_d     = k_q;
        g_d     = g_q;
`ifdef FFT_SCHED_BITREV_EN
        ro_d    = ro_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    stage_d = '0;
                    a_d     = '0;
                    wn_d    = '0;
                    k_d     = '0;
                    g_d     = '0;
                end
            end
            ST_RUN: begin
                if (hs) begin
                    if (last_k) begin
                        k_d  = '0;
                        wn_d = '0;
                        if (last_g) begin
                            state_d = ST_DRAIN;
                            a_d     = '0;
                            g_d     = '0;
                        end else begin
                            a_d = a_q + half + AW'(1);
                            g_d = g_q + AW'(1);
                        end
                    end else begin
                        k_d  = k_q + AW'(1);
                        a_d  = a_q + AW'(1);
                        wn_d = wn_q + groups;
                    end
                end
            end
            ST_DRAIN: begin
                // Mid-run stages wait for the counter to settle at zero; the final
                // stage hands over on the last writeback itself.
                if (!final_stage) begin
                    if (inflight == '0) begin
                        state_d = ST_RUN;
                        stage_d = stage_q + 8'd1;
                    end
                end else if (wb_vld && (inflight == CW'(1))) begin
`ifdef FFT_SCHED_BITREV_EN
                    state_d = ST_REORDER;
                    ro_d    = '0;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef FFT_SCHED_BITREV_EN
            ST_REORDER: begin
                if (iss_rdy) begin
                    ro_d = ro_q + 1'b1;
                    if (ro_q == '1) state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            a_q     <= '0;
            wn_q    <= '0;
            k_q     <= '0;
            g_q     <= '0;
`ifdef FFT_SCHED_BITREV_EN
            ro_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            a_q     <= a_d;
            wn_q    <= wn_d;
            k_q     <= k_d;
            g_q     <= g_d;
`ifdef FFT_SCHED_BITREV_EN
            ro_q    <= ro_d;
`endif
        end
    end

endmodule

// File: tb/tb_fft_btf_sched.sv
// tb/tb_fft_btf_sched.sv - self-checking bench for fft_btf_sched against a loop-built issue model
module tb_fft_btf_sched;

    localparam int LOG2N = 3;
    localparam int LAT   = 3;
    localparam int AW    = 16;
    localparam int N     = 1 << LOG2N;
    localparam int NB    = LOG2N * N / 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          iss_rdy = 1'b0;
    logic          busy, done, iss_vld, wb_vld;
    logic [AW-1:0] iss_a, iss_b, iss_wn, wb_a, wb_b;
    logic [7:0]    stage;
`ifdef FFT_SCHED_BITREV_EN
    logic          out_vld;
    logic [AW-1:0] out_idx;
`endif

    int total = 0;
    int bad   = 0;

    int ea[NB];
    int eb[NB];
    int ew[NB];
    int es[NB];
    int wq_c[$];
    int wq_a[$];
    int wq_b[$];
    int wq_s[$];

    fft_btf_sched #(
        .LOG2N   (LOG2N),
        .BTF_LAT (LAT),
        .AW      (AW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .iss_vld (iss_vld),
        .iss_rdy (iss_rdy),
        .iss_a   (iss_a),
        .iss_b   (iss_b),
        .iss_wn  (iss_wn),
        .stage   (stage),
        .wb_vld  (wb_vld),
        .wb_a    (wb_a),
        .wb_b    (wb_b)
`ifdef FFT_SCHED_BITREV_EN
        ,
        .out_vld (out_vld),
        .out_idx (out_idx)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_iss_vld"}, iss_vld, 0);
        chk({tag, "_iss_a"}, iss_a, 0);
        chk({tag, "_iss_b"}, iss_b, 0);
        chk({tag, "_iss_wn"}, iss_wn, 0);
        chk({tag, "_stage"}, stage, 0);
        chk({tag, "_wb_vld"}, wb_vld, 0);
        chk({tag, "_wb_a"}, wb_a, 0);
        chk({tag, "_wb_b"}, wb_b, 0);
    endtask

`ifdef FFT_SCHED_BITREV_EN
    function automatic int bitrev_ref(input int v);
        int r = 0;
        for (int i = 0; i < LOG2N; i++) begin
            if (((v >> i) & 1) != 0) r = r | (1 << (LOG2N - 1 - i));
        end
        return r;
    endfunction
`endif

    // Expected issue order straight from the DIF definition: stage, group, step.
    task automatic build_model();
        int i = 0;
        for (int s = 0; s < LOG2N; s++) begin
            int half = N >> (s + 1);
            for (int g = 0; g < (1 << s); g++) begin
                for (int k = 0; k < half; k++) begin
                    ea[i] = g * 2 * half + k;
                    eb[i] = ea[i] + half;
                    ew[i] = k << s;
                    es[i] = s;
                    i++;
                end
            end
        end
    endtask

    // mode 0: ready always, 1: 5-cycle stall after 2nd issue, 2: random ready.
    task automatic run_fft(input int mode, input int extra_start, input int rst_at);
        int idx        = 0;
        int nhs        = 0;
        int stalls     = 0;
        int stall_left = 0;
        int done_cnt   = 0;
        int done_cyc   = -1;
        int exp_done;
        bit rdy;
        bit exp_wb;
        bit aborted    = 0;
`ifdef FFT_SCHED_BITREV_EN
        int ro = 0;
`endif
        wq_c.delete();
        wq_a.delete();
        wq_b.delete();
        wq_s.delete();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            start = (c == 0) || (c == extra_start);
            if (c == rst_at) begin
                start   = 1'b0;
                iss_rdy = 1'b0;
                rst     = 1'b1;
                #1;
                chk_zero("mid_reset");
                aborted = 1;
                break;
            end
            case (mode)
                0: rdy = 1'b1;
                1: begin
                    if (stall_left > 0) begin
                        rdy = 1'b0;
                        stall_left--;
                    end else begin
                        rdy = 1'b1;
                    end
                end
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            iss_rdy = rdy;
            if (iss_vld) begin
                chk("issue_in_range", idx < NB, 1);
                if (idx < NB) begin
                    chk("iss_a", iss_a, ea[idx]);
                    chk("iss_b", iss_b, eb[idx]);
                    chk("iss_wn", iss_wn, ew[idx]);
                    chk("stage", stage, es[idx]);
                    if (wq_s.size() > 0) chk("stage_hazard", wq_s[0], es[idx]);
                    if (rdy) begin
                        wq_c.push_back(c + LAT);
                        wq_a.push_back(ea[idx]);
                        wq_b.push_back(eb[idx]);
                        wq_s.push_back(es[idx]);
                        idx++;
                        nhs++;
                        if (mode == 1 && nhs == 2) stall_left = 5;
                    end else begin
                        stalls++;
                    end
                end
            end
            exp_wb = (wq_c.size() > 0) && (wq_c[0] == c);
            chk("wb_vld", wb_vld, exp_wb);
            if (exp_wb) begin
                chk("wb_a", wb_a, wq_a[0]);
                chk("wb_b", wb_b, wq_b[0]);
                void'(wq_c.pop_front());
                void'(wq_a.pop_front());
                void'(wq_b.pop_front());
                void'(wq_s.pop_front());
            end
`ifdef FFT_SCHED_BITREV_EN
            if (out_vld) begin
                chk("out_idx", out_idx, bitrev_ref(ro));
                chk("reorder_after_drain", wq_c.size(), 0);
                if (rdy) ro++;
                else stalls++;
            end
`endif
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (c >= 1 && done_cnt == 0) chk("busy_run", busy, 1);
            if (done_cnt > 0 && c >= done_cyc + 3) break;
        end
        start   = 1'b0;
        iss_rdy = 1'b0;
        if (!aborted) begin
            exp_done = LOG2N * (N / 2 + LAT + 1) + stalls;
`ifdef FFT_SCHED_BITREV_EN
            exp_done = exp_done + N;
            chk("reorder_count", ro, N);
`endif
            chk("done_count", done_cnt, 1);
            chk("done_cycle", done_cyc, exp_done);
            chk("all_issued", idx, NB);
            chk("wb_drained", wq_c.size(), 0);
            chk("busy_idle", busy, 0);
        end else begin
            repeat (2) @(negedge clk);
            rst = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                chk("post_reset_wb_vld", wb_vld, 0);
                chk("post_reset_done", done, 0);
                chk("post_reset_iss_vld", iss_vld, 0);
            end
        end
    endtask

    initial begin
        build_model();
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        run_fft(0, -1, -1);
        run_fft(1, -1, -1);
        run_fft(0, 10, -1);
        run_fft(0, -1, 12);
        run_fft(0, -1, -1);
        for (int r = 0; r < 4; r++) run_fft(2, -1, -1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
